// File: rtl/vend_dispense_ctrl.sv
// Vending dispense sequencer: product motor, drop sensing, coin payout and stock/sold-out bookkeeping.
// Latency: a product vend with no change and a first-cycle drop finishes MOTOR_CYCLES+2 cycles after its handshake cycle.
// Backpressure: one request at a time; req_ready is low while busy or while a restock strobe is present.
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES = 4,
    parameter int DROP_TIMEOUT = 15,
    parameter int INIT_STOCK   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_product,
    input  logic [3:0] req_change,
    output logic [2:0] motor_en,
    input  logic       drop_sense,
    output logic       coin5_eject,
    output logic       coin1_eject,
    input  logic       coin_ack,
    input  logic       load_stock,
    input  logic [1:0] load_sel,
    input  logic [5:0] load_value,
    output logic [5:0] stock1,
    output logic [5:0] stock2,
    output logic [5:0] stock3,
    output logic [2:0] soldout,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic       reject
);

    // One shared counter times both the motor phase and the drop timeout.
    localparam int CNT_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MOTOR_LAST = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] DROP_LAST  = CW'(DROP_TIMEOUT - 1);
    localparam logic [5:0]    STOCK_RST  = 6'(INIT_STOCK);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOTOR     = 3'd1,
        WAIT_DROP = 3'd2,
        COIN5     = 3'd3,
        COIN5_ACK = 3'd4,
        COIN1     = 3'd5,
        COIN1_ACK = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      prod_q, prod_d;
    logic [3:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ok_q, ok_d;
    logic            reject_q, reject_d;
    logic [2:0][5:0] stock_q, stock_d;
    logic            drop_to;
    logic            req_soldout;

    // Where the coin phase starts (or ends) for a given amount still owed.
    function automatic state_t coin_entry(input logic [3:0] r);
        if (r >= 4'd5)
            return COIN5;
        else if (r != 4'd0)
            return COIN1;
        else
            return DONE;
    endfunction

    function automatic logic [5:0] dec_sat(input logic [5:0] v);
        return (v == 6'd0) ? 6'd0 : v - 6'd1;
    endfunction

    // Sold-out status of the product named on the request bus.
    always_comb begin
        req_soldout = 1'b0;
        case (req_product)
            2'd1:    req_soldout = soldout[0];
            2'd2:    req_soldout = soldout[1];
            2'd3:    req_soldout = soldout[2];
            default: req_soldout = 1'b0;
        endcase
    end

    // Next-state, datapath updates and actuator outputs.
    always_comb begin
        state_d     = state_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        ok_d        = ok_q;
        reject_d    = 1'b0;
        stock_d     = stock_q;
        motor_en    = 3'b000;
        coin5_eject = 1'b0;
        coin1_eject = 1'b0;
        drop_to     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_stock) begin
                    // Restock wins over a same-cycle request; load_sel 0 is a no-op.
                    case (load_sel)
                        2'd1:    stock_d[0] = load_value;
                        2'd2:    stock_d[1] = load_value;
                        2'd3:    stock_d[2] = load_value;
                        default: ;
                    endcase
                end else if (req_valid) begin
                    prod_d = req_product;
                    rem_d  = req_change;
                    cnt_d  = '0;
                    if (req_product == 2'd0)
                        state_d = coin_entry(req_change);
                    else if (req_soldout)
                        reject_d = 1'b1;
                    else
                        state_d = MOTOR;
                end
            end
            MOTOR: begin
                case (prod_q)
                    2'd1:    motor_en = 3'b001;
                    2'd2:    motor_en = 3'b010;
                    2'd3:    motor_en = 3'b100;
                    default: motor_en = 3'b000;
                endcase
                if (cnt_q == MOTOR_LAST) begin
                    state_d = WAIT_DROP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DROP: begin
                if (drop_sense) begin
                    case (prod_q)
                        2'd1:    stock_d[0] = dec_sat(stock_q[0]);
                        2'd2:    stock_d[1] = dec_sat(stock_q[1]);
                        2'd3:    stock_d[2] = dec_sat(stock_q[2]);
                        default: ;
                    endcase
                    state_d = coin_entry(rem_q);
                end else if (cnt_q == DROP_LAST) begin
                    // No product fell: finish without touching stock or paying change.
                    state_d = DONE;
                    drop_to = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COIN5: begin
                coin5_eject = 1'b1;
                if (coin_ack) begin
                    rem_d   = rem_q - 4'd5;
                    state_d = COIN5_ACK;
                end
            end
            COIN1: begin
                coin1_eject = 1'b1;
                if (coin_ack) begin
                    rem_d   = rem_q - 4'd1;
                    state_d = COIN1_ACK;
                end
            end
            COIN5_ACK, COIN1_ACK: begin
                state_d = coin_entry(rem_q);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ok is refreshed only on entry to DONE and holds until the next completion.
        if (state_d == DONE && state_q != DONE)
            ok_d = !drop_to;
    end

    // State and datapath registers; reset aborts any vend in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prod_q   <= 2'd0;
            rem_q    <= 4'd0;
            cnt_q    <= '0;
            ok_q     <= 1'b0;
            reject_q <= 1'b0;
            stock_q  <= {3{STOCK_RST}};
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            reject_q <= reject_d;
            stock_q  <= stock_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !load_stock;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ok        = ok_q;
    assign reject    = reject_q;
    assign stock1    = stock_q[0];
    assign stock2    = stock_q[1];
    assign stock3    = stock_q[2];
    assign soldout   = {stock_q[2] == 6'd0, stock_q[1] == 6'd0, stock_q[0] == 6'd0};

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with a completion scoreboard.
// Expectations are queued per request and checked when done or reject fires.
// A coin-ejector model acknowledges each strobe two cycles after it rises.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_product;
    logic [3:0] req_change;
    logic [2:0] motor_en;
    logic       drop_sense;
    logic       coin5_eject;
    logic       coin1_eject;
    logic       coin_ack;
    logic       load_stock;
    logic [1:0] load_sel;
    logic [5:0] load_value;
    logic [5:0] stock1, stock2, stock3;
    logic [2:0] soldout;
    logic       busy, done, ok, reject;

    vend_dispense_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_product (req_product),
        .req_change  (req_change),
        .motor_en    (motor_en),
        .drop_sense  (drop_sense),
        .coin5_eject (coin5_eject),
        .coin1_eject (coin1_eject),
        .coin_ack    (coin_ack),
        .load_stock  (load_stock),
        .load_sel    (load_sel),
        .load_value  (load_value),
        .stock1      (stock1),
        .stock2      (stock2),
        .stock3      (stock3),
        .soldout     (soldout),
        .busy        (busy),
        .done        (done),
        .ok          (ok),
        .reject      (reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rej;
        bit         ok;
        int         n5;
        int         n1;
        int         mcyc;
        logic [2:0] mval;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   stk[1:3];
    bit   ack_en;
    int   ack_wait;

    int         n5_c, n1_c, mcyc_c, ovl_c, lat_c;
    logic [2:0] mval_c;
    logic       p5, p1;

    function automatic exp_t mk(input bit rj, input bit k, input int a5, input int a1,
                                input int mc, input logic [2:0] mv, input int lt);
        exp_t e;
        e.rej = rj; e.ok = k; e.n5 = a5; e.n1 = a1; e.mcyc = mc; e.mval = mv; e.lat = lt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Coin ejector model: acknowledge two cycles after an eject strobe appears.
    always @(negedge clk) begin
        if (rst || !ack_en) begin
            coin_ack = 1'b0;
            ack_wait = 0;
        end else if (coin_ack) begin
            coin_ack = 1'b0;
            ack_wait = 0;
        end else if (coin5_eject || coin1_eject) begin
            ack_wait++;
            if (ack_wait == 2) coin_ack = 1'b1;
        end else begin
            ack_wait = 0;
        end
    end

    // Monitor: accumulate activity per request and score it at done/reject.
    always @(negedge clk) begin
        if (rst) begin
            n5_c = 0; n1_c = 0; mcyc_c = 0; ovl_c = 0; lat_c = 0; mval_c = 3'b000;
            p5 = 1'b0; p1 = 1'b0;
        end else begin
            if (busy) lat_c++; else lat_c = 0;
            if (coin5_eject && !p5) n5_c++;
            if (coin1_eject && !p1) n1_c++;
            p5 = coin5_eject;
            p1 = coin1_eject;
            if (coin5_eject && coin1_eject) ovl_c++;
            if (motor_en != 3'b000) begin
                mcyc_c++;
                mval_c = mval_c | motor_en;
            end
            if (done || reject) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check("reject", reject, cur.rej);
                    check("done", done, !cur.rej);
                    if (!cur.rej) check("ok", ok, cur.ok);
                    check("coin5_pulses", n5_c, cur.n5);
                    check("coin1_pulses", n1_c, cur.n1);
                    check("motor_cycles", mcyc_c, cur.mcyc);
                    check("motor_sel", mval_c, cur.mval);
                    check("eject_overlap", ovl_c, 0);
                    if (cur.lat >= 0) check("latency", lat_c, cur.lat);
                end
                n5_c = 0; n1_c = 0; mcyc_c = 0; ovl_c = 0; mval_c = 3'b000;
            end
        end
    end

    task automatic send(input logic [1:0] p, input logic [3:0] c, input exp_t e);
        @(negedge clk);
        req_valid   = 1'b1;
        req_product = p;
        req_change  = c;
        sb.push_back(e);
        #1 check("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called one negedge after the handshake edge; drop arrives in the first WAIT_DROP cycle.
    task automatic drop_phase(input bit d);
        repeat (3) @(negedge clk);
        @(negedge clk);
        drop_sense = d;
        @(negedge clk);
        drop_sense = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_product = 2'd0; req_change = 4'd0;
        drop_sense = 1'b0; load_stock = 1'b0; load_sel = 2'd0; load_value = 6'd0;
        ack_en = 1'b1;
        stk[1] = 32; stk[2] = 32; stk[3] = 32;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_motor", motor_en, 0);
        check("rst_c5", coin5_eject, 0);
        check("rst_c1", coin1_eject, 0);
        check("rst_done", done, 0);
        check("rst_ok", ok, 0);
        check("rst_reject", reject, 0);
        check("rst_stock1", stock1, stk[1]);
        check("rst_stock2", stock2, stk[2]);
        check("rst_stock3", stock3, stk[3]);
        check("rst_soldout", soldout, 0);
        rst = 1'b0;

        // Product 1, no change, drop in first WAIT_DROP cycle
        send(2'd1, 4'd0, mk(0, 1, 0, 0, 4, 3'b001, 6));
        drop_phase(1'b1);
        wait_idle("t1_idle", 20);
        stk[1] = 31;
        check("t1_stock1", stock1, stk[1]);

        // Product 2 with change 12: two fives then two ones
        send(2'd2, 4'd12, mk(0, 1, 2, 2, 4, 3'b010, -1));
        drop_phase(1'b1);
        wait_idle("t2_idle", 200);
        stk[2] = 31;
        check("t2_stock2", stock2, stk[2]);

        // Product 3 with change owed but no drop: timeout, no coins
        send(2'd3, 4'd9, mk(0, 0, 0, 0, 4, 3'b100, 20));
        drop_phase(1'b0);
        wait_idle("t3_idle", 50);
        check("t3_stock3", stock3, stk[3]);
        @(negedge clk);
        check("t3_ok_hold", ok, 0);

        // Restock product 1 to zero, then load_sel 0 is ignored
        @(negedge clk);
        load_stock = 1'b1; load_sel = 2'd1; load_value = 6'd0;
        #1 check("t4_rdy_lo", req_ready, 0);
        @(negedge clk);
        load_stock = 1'b0;
        stk[1] = 0;
        check("t4_stock1", stock1, stk[1]);
        check("t4_soldout", soldout, 3'b001);
        load_stock = 1'b1; load_sel = 2'd0; load_value = 6'd9;
        @(negedge clk);
        load_stock = 1'b0;
        check("t4_sel0_s1", stock1, stk[1]);
        check("t4_sel0_s2", stock2, stk[2]);
        check("t4_sel0_s3", stock3, stk[3]);

        // Sold-out product 1 is refused
        send(2'd1, 4'd4, mk(1, 0, 0, 0, 0, 3'b000, 0));
        check("t4_rej_idle", busy, 0);
        @(negedge clk);
        check("t4_rej_pulse", reject, 0);
        check("t4_rej_stock1", stock1, stk[1]);

        // Change-only requests
        send(2'd0, 4'd7, mk(0, 1, 1, 2, 0, 3'b000, -1));
        wait_idle("t5_idle", 100);
        send(2'd0, 4'd0, mk(0, 1, 0, 0, 0, 3'b000, 1));
        wait_idle("t5b_idle", 10);

        // Reset while a 1-unit coin strobe is held
        ack_en = 1'b0;
        send(2'd0, 4'd3, mk(0, 1, 0, 3, 0, 3'b000, -1));
        for (int i = 0; i < 10 && !coin1_eject; i++) @(negedge clk);
        check("t6_c1_high", coin1_eject, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        stk[1] = 32; stk[2] = 32; stk[3] = 32;
        check("t6_c1_drop", coin1_eject, 0);
        check("t6_busy", busy, 0);
        check("t6_ok", ok, 0);
        check("t6_stock1", stock1, stk[1]);
        check("t6_stock2", stock2, stk[2]);
        check("t6_stock3", stock3, stk[3]);
        check("t6_soldout", soldout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;

        // Restock and request in the same cycle: restock first, handshake next cycle
        @(negedge clk);
        load_stock = 1'b1; load_sel = 2'd2; load_value = 6'd20;
        req_valid = 1'b1; req_product = 2'd3; req_change = 4'd0;
        #1 check("t7_rdy_lo", req_ready, 0);
        @(negedge clk);
        load_stock = 1'b0; load_sel = 2'd0;
        stk[2] = 20;
        #1 check("t7_rdy_hi", req_ready, 1);
        check("t7_stock2", stock2, stk[2]);
        sb.push_back(mk(0, 1, 0, 0, 4, 3'b100, 6));
        @(negedge clk);
        req_valid = 1'b0;
        drop_phase(1'b1);
        wait_idle("t7_idle", 20);
        stk[3] = 31;
        check("t7_stock3", stock3, stk[3]);
        check("t7_stock2_keep", stock2, stk[2]);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
